// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// ---------------
// Shares the single off-core memory command port between the instruction
// cache and the data cache.
//
// Arbitration and return routing:
// - Each cycle one requester is granted, combinationally and with zero
//   latency. The dcache has priority.
// - The icache is promoted for one grant once it has lost STARVE_LIMIT times
//   in a row. The promotion survives memory rejections until a load is
//   accepted.
// - Every accepted load records which side owns the memory tag it was given.
//   Returning data for that tag is steered only to the owner.
// - Each side may have at most MAX_OUTSTANDING loads in flight. Further loads
//   from a side at its limit are not eligible for a grant.
//
// Ports:
//   clock, reset                      clock, asynchronous active-high reset
//   icache2arb_command/addr           icache request (loads only)
//   dcache2arb_command/addr/data      dcache request (loads and stores)
//   arb2mem_command/addr/data         granted request forwarded to memory
//   mem2arb_response                  acceptance tag from memory (0 = rejected)
//   mem2arb_data/tag                  returning load data and its tag (0 = none)
//   arb2icache_response/data/tag      icache view of acceptance and returns
//   arb2dcache_response/data/tag      dcache view of acceptance and returns
//   arb_dcache_granted                dcache holds the bus this cycle
//   arb_tag_error                     sticky tag bookkeeping error

`ifndef XLEN
`define XLEN 64
`endif

module mem_bus_arbiter #(
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int XLEN            = `XLEN
) (
  input  logic            clock,
  input  logic            reset,

  input  logic [1:0]      icache2arb_command,
  input  logic [XLEN-1:0] icache2arb_addr,

  input  logic [1:0]      dcache2arb_command,
  input  logic [XLEN-1:0] dcache2arb_addr,
  input  logic [63:0]     dcache2arb_data,

  output logic [1:0]      arb2mem_command,
  output logic [XLEN-1:0] arb2mem_addr,
  output logic [63:0]     arb2mem_data,

  input  logic [3:0]      mem2arb_response,
  input  logic [63:0]     mem2arb_data,
  input  logic [3:0]      mem2arb_tag,

  output logic [3:0]      arb2icache_response,
  output logic [63:0]     arb2icache_data,
  output logic [3:0]      arb2icache_tag,

  output logic [3:0]      arb2dcache_response,
  output logic [63:0]     arb2dcache_data,
  output logic [3:0]      arb2dcache_tag,

  output logic            arb_dcache_granted,
  output logic            arb_tag_error
);

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_ICACHE = 2'd1,
    GNT_DCACHE = 2'd2
  } grant_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0]      owner_valid_reg, owner_valid_next;
  logic [15:0]      owner_is_d_reg,  owner_is_d_next;
  logic [CNT_W-1:0] i_outst_reg,     i_outst_next;
  logic [CNT_W-1:0] d_outst_reg,     d_outst_next;
  logic [STV_W-1:0] starve_cnt_reg,  starve_cnt_next;
  logic             err_reg,         err_next;

  // ---------------------------------------------------------------------------
  // Eligibility and grant
  // ---------------------------------------------------------------------------
  logic   i_req;
  logic   d_req;
  grant_e grant;

  always_comb begin
    i_req = (icache2arb_command == BUS_LOAD) && (i_outst_reg < CNT_MAX);
    // Stores never occupy a tag, so the load limit does not gate them.
    d_req = (dcache2arb_command != BUS_NONE) &&
            ((dcache2arb_command == BUS_STORE) || (d_outst_reg < CNT_MAX));

    grant = GNT_NONE;
    if (reset) begin
      grant = GNT_NONE;
    end else if (i_req && d_req) begin
      if (starve_cnt_reg == STV_MAX) begin
        grant = GNT_ICACHE;
      end else begin
        grant = GNT_DCACHE;
      end
    end else if (i_req) begin
      grant = GNT_ICACHE;
    end else if (d_req) begin
      grant = GNT_DCACHE;
    end
  end

  // Granted request passes straight through; the bus is quiet otherwise.
  always_comb begin
    arb2mem_command = BUS_NONE;
    arb2mem_addr    = '0;
    arb2mem_data    = '0;
    case (grant)
      GNT_ICACHE: begin
        arb2mem_command = icache2arb_command;
        arb2mem_addr    = icache2arb_addr;
      end
      GNT_DCACHE: begin
        arb2mem_command = dcache2arb_command;
        arb2mem_addr    = dcache2arb_addr;
        arb2mem_data    = dcache2arb_data;
      end
      default: begin
      end
    endcase
  end

  assign arb_dcache_granted  = (grant == GNT_DCACHE);
  assign arb2icache_response = (grant == GNT_ICACHE) ? mem2arb_response : 4'd0;
  assign arb2dcache_response = (grant == GNT_DCACHE) ? mem2arb_response : 4'd0;

  logic accept;
  logic load_accept;

  assign accept      = (grant != GNT_NONE) && (mem2arb_response != 4'd0);
  assign load_accept = accept && (arb2mem_command == BUS_LOAD);

  // ---------------------------------------------------------------------------
  // Return routing
  // ---------------------------------------------------------------------------
  logic ret_present;
  logic ret_hit;
  logic ret_miss;
  logic ret_to_i;
  logic ret_to_d;

  assign ret_present = !reset && (mem2arb_tag != 4'd0);
  assign ret_hit     = ret_present && owner_valid_reg[mem2arb_tag];
  assign ret_miss    = ret_present && !owner_valid_reg[mem2arb_tag];
  assign ret_to_d    = ret_hit && owner_is_d_reg[mem2arb_tag];
  assign ret_to_i    = ret_hit && !owner_is_d_reg[mem2arb_tag];

  assign arb2icache_tag  = ret_to_i ? mem2arb_tag  : 4'd0;
  assign arb2icache_data = ret_to_i ? mem2arb_data : 64'd0;
  assign arb2dcache_tag  = ret_to_d ? mem2arb_tag  : 4'd0;
  assign arb2dcache_data = ret_to_d ? mem2arb_data : 64'd0;

  // ---------------------------------------------------------------------------
  // Tag ownership table
  // ---------------------------------------------------------------------------
  // A return and a new acceptance on the same tag in one cycle resolve as
  // "clear, then set", so set wins over clear on each entry.
  logic [15:0] set_vec;
  logic [15:0] clr_vec;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_owner
      assign set_vec[gi]          = load_accept && (mem2arb_response == 4'(gi));
      assign clr_vec[gi]          = ret_hit && (mem2arb_tag == 4'(gi));
      assign owner_valid_next[gi] = set_vec[gi] | (owner_valid_reg[gi] & ~clr_vec[gi]);
      assign owner_is_d_next[gi]  = set_vec[gi] ? (grant == GNT_DCACHE) : owner_is_d_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outstanding-load counters
  // ---------------------------------------------------------------------------
  logic i_inc, i_dec, i_uflow;
  logic d_inc, d_dec, d_uflow;

  assign i_inc = load_accept && (grant == GNT_ICACHE);
  assign d_inc = load_accept && (grant == GNT_DCACHE);
  assign i_dec = ret_to_i;
  assign d_dec = ret_to_d;

  // Simultaneous increment and decrement cancel; a decrement at zero is
  // dropped and reported as an error instead of wrapping.
  always_comb begin
    i_outst_next = i_outst_reg;
    i_uflow      = 1'b0;
    if (i_inc && !i_dec) begin
      i_outst_next = i_outst_reg + 1'b1;
    end else if (!i_inc && i_dec) begin
      if (i_outst_reg == '0) begin
        i_uflow = 1'b1;
      end else begin
        i_outst_next = i_outst_reg - 1'b1;
      end
    end
  end

  always_comb begin
    d_outst_next = d_outst_reg;
    d_uflow      = 1'b0;
    if (d_inc && !d_dec) begin
      d_outst_next = d_outst_reg + 1'b1;
    end else if (!d_inc && d_dec) begin
      if (d_outst_reg == '0) begin
        d_uflow = 1'b1;
      end else begin
        d_outst_next = d_outst_reg - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter
  // ---------------------------------------------------------------------------
  // Counts every cycle the icache wants the bus but does not get a load
  // accepted. A rejected grant does not clear it, so priority is kept.
  logic i_won;

  assign i_won = (grant == GNT_ICACHE) && (mem2arb_response != 4'd0);

  always_comb begin
    starve_cnt_next = '0;
    if (i_req && !i_won) begin
      if (starve_cnt_reg == STV_MAX) begin
        starve_cnt_next = starve_cnt_reg;
      end else begin
        starve_cnt_next = starve_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error flag
  // ---------------------------------------------------------------------------
  // Re-using a tag that is still owned is an error unless that same tag is
  // retiring in this very cycle.
  logic dup_set;

  assign dup_set = load_accept && owner_valid_reg[mem2arb_response] &&
                   !(ret_hit && (mem2arb_tag == mem2arb_response));

  assign err_next      = err_reg | ret_miss | dup_set | i_uflow | d_uflow;
  assign arb_tag_error = err_reg;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_valid_reg <= '0;
      owner_is_d_reg  <= '0;
      i_outst_reg     <= '0;
      d_outst_reg     <= '0;
      starve_cnt_reg  <= '0;
      err_reg         <= 1'b0;
    end else begin
      owner_valid_reg <= owner_valid_next;
      owner_is_d_reg  <= owner_is_d_next;
      i_outst_reg     <= i_outst_next;
      d_outst_reg     <= d_outst_next;
      starve_cnt_reg  <= starve_cnt_next;
      err_reg         <= err_next;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// ------------------
// Directed bench for mem_bus_arbiter. Stimulus pushes the expected grant and
// return transactions into queues; a monitor on the falling clock edge pops
// and compares whenever the arbiter presents a grant or a returned tag.

`timescale 1ns/1ps

`ifndef XLEN
`define XLEN 64
`endif

module tb_mem_bus_arbiter;

  localparam int XL = `XLEN;

  localparam logic [1:0] NONE  = 2'h0;
  localparam logic [1:0] LOAD  = 2'h1;
  localparam logic [1:0] STORE = 2'h2;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    icmd;
  logic [XL-1:0] iaddr;
  logic [1:0]    dcmd;
  logic [XL-1:0] daddr;
  logic [63:0]   ddata;
  logic [1:0]    arb2mem_command;
  logic [XL-1:0] arb2mem_addr;
  logic [63:0]   arb2mem_data;
  logic [3:0]    resp;
  logic [63:0]   mdata;
  logic [3:0]    mtag;
  logic [3:0]    arb2icache_response;
  logic [63:0]   arb2icache_data;
  logic [3:0]    arb2icache_tag;
  logic [3:0]    arb2dcache_response;
  logic [63:0]   arb2dcache_data;
  logic [3:0]    arb2dcache_tag;
  logic          arb_dcache_granted;
  logic          arb_tag_error;

  mem_bus_arbiter #(
    .STARVE_LIMIT   (4),
    .MAX_OUTSTANDING(8),
    .XLEN           (XL)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .icache2arb_command (icmd),
    .icache2arb_addr    (iaddr),
    .dcache2arb_command (dcmd),
    .dcache2arb_addr    (daddr),
    .dcache2arb_data    (ddata),
    .arb2mem_command    (arb2mem_command),
    .arb2mem_addr       (arb2mem_addr),
    .arb2mem_data       (arb2mem_data),
    .mem2arb_response   (resp),
    .mem2arb_data       (mdata),
    .mem2arb_tag        (mtag),
    .arb2icache_response(arb2icache_response),
    .arb2icache_data    (arb2icache_data),
    .arb2icache_tag     (arb2icache_tag),
    .arb2dcache_response(arb2dcache_response),
    .arb2dcache_data    (arb2dcache_data),
    .arb2dcache_tag     (arb2dcache_tag),
    .arb_dcache_granted (arb_dcache_granted),
    .arb_tag_error      (arb_tag_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        d;
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [3:0]  iresp;
    logic [3:0]  dresp;
  } gnt_t;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] data;
  } ret_t;

  gnt_t gq[$];
  ret_t iq[$];
  ret_t dq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_gnt(input logic d, input logic [1:0] cmd, input logic [63:0] addr,
                         input logic [63:0] data, input logic [3:0] iresp, input logic [3:0] dresp);
    gnt_t g;
    g.d = d; g.cmd = cmd; g.addr = addr; g.data = data; g.iresp = iresp; g.dresp = dresp;
    gq.push_back(g);
  endtask

  task automatic exp_iret(input logic [3:0] tag, input logic [63:0] data);
    ret_t r;
    r.tag = tag; r.data = data;
    iq.push_back(r);
  endtask

  task automatic exp_dret(input logic [3:0] tag, input logic [63:0] data);
    ret_t r;
    r.tag = tag; r.data = data;
    dq.push_back(r);
  endtask

  task automatic idle_inputs();
    icmd = NONE; iaddr = '0;
    dcmd = NONE; daddr = '0; ddata = '0;
    resp = '0; mtag = '0; mdata = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  initial begin
    gnt_t g;
    ret_t r;
    forever begin
      @(negedge clock);
      if (arb2mem_command != NONE) begin
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: got cmd %0d addr 0x%0h, expected no grant (t=%0t)",
                   arb2mem_command, arb2mem_addr, $time);
        end else begin
          g = gq.pop_front();
          $display("grant d=%0b cmd=%0d addr=0x%0h iresp=%0d dresp=%0d",
                   arb_dcache_granted, arb2mem_command, arb2mem_addr,
                   arb2icache_response, arb2dcache_response);
          chk("grant_is_dcache", 64'(arb_dcache_granted), 64'(g.d));
          chk("grant_command", 64'(arb2mem_command), 64'(g.cmd));
          chk("grant_addr", 64'(arb2mem_addr), g.addr);
          chk("grant_data", arb2mem_data, g.data);
          chk("grant_icache_response", 64'(arb2icache_response), 64'(g.iresp));
          chk("grant_dcache_response", 64'(arb2dcache_response), 64'(g.dresp));
        end
      end else begin
        chk("idle_dcache_granted", 64'(arb_dcache_granted), 64'd0);
        chk("idle_icache_response", 64'(arb2icache_response), 64'd0);
        chk("idle_dcache_response", 64'(arb2dcache_response), 64'd0);
      end

      if (arb2icache_tag != 4'd0) begin
        if (iq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_icache_return: got tag %0d, expected none (t=%0t)",
                   arb2icache_tag, $time);
        end else begin
          r = iq.pop_front();
          $display("icache return tag=%0d data=0x%0h", arb2icache_tag, arb2icache_data);
          chk("icache_return_tag", 64'(arb2icache_tag), 64'(r.tag));
          chk("icache_return_data", arb2icache_data, r.data);
        end
      end else if (mtag != 4'd0) begin
        chk("icache_nonowner_data", arb2icache_data, 64'd0);
      end

      if (arb2dcache_tag != 4'd0) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dcache_return: got tag %0d, expected none (t=%0t)",
                   arb2dcache_tag, $time);
        end else begin
          r = dq.pop_front();
          $display("dcache return tag=%0d data=0x%0h", arb2dcache_tag, arb2dcache_data);
          chk("dcache_return_tag", 64'(arb2dcache_tag), 64'(r.tag));
          chk("dcache_return_data", arb2dcache_data, r.data);
        end
      end else if (mtag != 4'd0) begin
        chk("dcache_nonowner_data", arb2dcache_data, 64'd0);
      end
    end
  end

  initial begin
    // Reset with busy inputs: every output must stay quiet.
    reset = 1'b1;
    idle_inputs();
    icmd = LOAD; iaddr = 'h40; dcmd = STORE; daddr = 'h80; ddata = 64'h1234;
    resp = 4'd3; mtag = 4'd3; mdata = 64'hFFFF;
    step();
    chk("reset_mem_command", 64'(arb2mem_command), 64'd0);
    chk("reset_mem_addr", 64'(arb2mem_addr), 64'd0);
    chk("reset_mem_data", arb2mem_data, 64'd0);
    chk("reset_icache_tag", 64'(arb2icache_tag), 64'd0);
    chk("reset_dcache_tag", 64'(arb2dcache_tag), 64'd0);
    chk("reset_dcache_granted", 64'(arb_dcache_granted), 64'd0);
    chk("reset_tag_error", 64'(arb_tag_error), 64'd0);
    step();
    idle_inputs();
    reset = 1'b0;
    step();

    // S1: dcache-only load, later returned.
    dcmd = LOAD; daddr = 'h100; ddata = 64'h55; resp = 4'd3;
    exp_gnt(1'b1, LOAD, 64'h100, 64'h55, 4'd0, 4'd3);
    step();
    idle_inputs();
    step();
    mtag = 4'd3; mdata = 64'hDEAD;
    exp_dret(4'd3, 64'hDEAD);
    #1;
    chk("s1_icache_tag_zero", 64'(arb2icache_tag), 64'd0);
    step();
    idle_inputs();
    chk("s1_d_outst_zero", 64'(dut.d_outst_reg), 64'd0);

    // S2: both loading every cycle, memory always accepting.
    icmd = LOAD; iaddr = 'h2000; dcmd = LOAD; daddr = 'h3000;
    for (int k = 1; k <= 10; k++) begin
      resp = 4'(k);
      if (k % 5 == 0) exp_gnt(1'b0, LOAD, 64'h2000, 64'd0, 4'(k), 4'd0);
      else            exp_gnt(1'b1, LOAD, 64'h3000, 64'd0, 4'd0, 4'(k));
      step();
    end
    idle_inputs();
    for (int k = 1; k <= 10; k++) begin
      mtag = 4'(k); mdata = 64'h1000 + 64'(k);
      if (k % 5 == 0) exp_iret(4'(k), 64'h1000 + 64'(k));
      else            exp_dret(4'(k), 64'h1000 + 64'(k));
      step();
    end
    idle_inputs();
    chk("s2_tag_error_clear", 64'(arb_tag_error), 64'd0);

    // S3: icache promoted by starvation, rejected twice, then accepted.
    icmd = LOAD; iaddr = 'h4000; dcmd = LOAD; daddr = 'h5000;
    for (int k = 1; k <= 4; k++) begin
      resp = 4'(k);
      exp_gnt(1'b1, LOAD, 64'h5000, 64'd0, 4'd0, 4'(k));
      step();
    end
    resp = 4'd0;
    exp_gnt(1'b0, LOAD, 64'h4000, 64'd0, 4'd0, 4'd0);
    step();
    exp_gnt(1'b0, LOAD, 64'h4000, 64'd0, 4'd0, 4'd0);
    step();
    resp = 4'd7;
    exp_gnt(1'b0, LOAD, 64'h4000, 64'd0, 4'd7, 4'd0);
    step();
    resp = 4'd8;
    exp_gnt(1'b1, LOAD, 64'h5000, 64'd0, 4'd0, 4'd8);
    step();
    idle_inputs();
    for (int k = 1; k <= 8; k++) begin
      if (k == 5 || k == 6) continue;
      mtag = 4'(k); mdata = 64'h2000 + 64'(k);
      if (k == 7) exp_iret(4'(k), 64'h2000 + 64'(k));
      else        exp_dret(4'(k), 64'h2000 + 64'(k));
      step();
    end
    idle_inputs();

    // S4: icache outstanding limit.
    icmd = LOAD; iaddr = 'h6000;
    for (int k = 1; k <= 8; k++) begin
      resp = 4'(k);
      exp_gnt(1'b0, LOAD, 64'h6000, 64'd0, 4'(k), 4'd0);
      step();
    end
    dcmd = LOAD; daddr = 'h7000; resp = 4'd9;
    exp_gnt(1'b1, LOAD, 64'h7000, 64'd0, 4'd0, 4'd9);
    step();
    dcmd = NONE; daddr = '0; resp = 4'd0; mtag = 4'd1; mdata = 64'hA1;
    exp_iret(4'd1, 64'hA1);
    #1;
    chk("s4_icache_blocked", 64'(arb2mem_command), 64'(NONE));
    step();
    mtag = 4'd0; mdata = '0; resp = 4'd10;
    exp_gnt(1'b0, LOAD, 64'h6000, 64'd0, 4'd10, 4'd0);
    step();
    idle_inputs();
    for (int k = 2; k <= 10; k++) begin
      mtag = 4'(k); mdata = 64'h3000 + 64'(k);
      if (k == 9) exp_dret(4'(k), 64'h3000 + 64'(k));
      else        exp_iret(4'(k), 64'h3000 + 64'(k));
      step();
    end
    idle_inputs();

    // S5: tag 5 retires to dcache while icache is accepted on tag 5.
    dcmd = LOAD; daddr = 'h8000; resp = 4'd5;
    exp_gnt(1'b1, LOAD, 64'h8000, 64'd0, 4'd0, 4'd5);
    step();
    idle_inputs();
    icmd = LOAD; iaddr = 'h9000; resp = 4'd5; mtag = 4'd5; mdata = 64'hBEEF;
    exp_gnt(1'b0, LOAD, 64'h9000, 64'd0, 4'd5, 4'd0);
    exp_dret(4'd5, 64'hBEEF);
    step();
    idle_inputs();
    chk("s5_owner_valid_5", 64'(dut.owner_valid_reg[5]), 64'd1);
    chk("s5_owner_is_d_5", 64'(dut.owner_is_d_reg[5]), 64'd0);
    chk("s5_tag_error", 64'(arb_tag_error), 64'd0);
    mtag = 4'd5; mdata = 64'hCAFE;
    exp_iret(4'd5, 64'hCAFE);
    step();
    idle_inputs();

    // S6: unknown tag return sets the sticky error.
    mtag = 4'd9; mdata = 64'h99;
    #1;
    chk("s6_icache_tag_zero", 64'(arb2icache_tag), 64'd0);
    chk("s6_dcache_tag_zero", 64'(arb2dcache_tag), 64'd0);
    step();
    idle_inputs();
    chk("s6_tag_error_set", 64'(arb_tag_error), 64'd1);
    step();
    chk("s6_tag_error_sticky", 64'(arb_tag_error), 64'd1);

    // S7: reset asserted mid-stream clears outputs before the next edge.
    dcmd = LOAD; daddr = 'hA000; resp = 4'd11;
    #1;
    chk("s7_pre_reset_dgrant", 64'(arb_dcache_granted), 64'd1);
    reset = 1'b1;
    #1;
    chk("s7_reset_mem_command", 64'(arb2mem_command), 64'd0);
    chk("s7_reset_mem_addr", 64'(arb2mem_addr), 64'd0);
    chk("s7_reset_dcache_response", 64'(arb2dcache_response), 64'd0);
    chk("s7_reset_dcache_granted", 64'(arb_dcache_granted), 64'd0);
    chk("s7_reset_tag_error", 64'(arb_tag_error), 64'd0);
    step();
    idle_inputs();
    reset = 1'b0;
    step();
    chk("s7_post_reset_tag_error", 64'(arb_tag_error), 64'd0);

    @(negedge clock);
    #1;
    chk("grant_queue_drained", 64'(gq.size()), 64'd0);
    chk("icache_queue_drained", 64'(iq.size()), 64'd0);
    chk("dcache_queue_drained", 64'(dq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single off-core memory port between the instruction cache and the data cache.
- Each cycle, grants the memory command bus to one requester. Returns the memory's response tag to the granted requester only.
- Tracks which requester owns each outstanding 4-bit memory tag, and routes returning tagged data to that owner.
- Sits between icache/dcache and the memory model. Provides D-side priority, I-side anti-starvation, and per-requester outstanding-load limits.

Parameters:
- STARVE_LIMIT, 4: consecutive icache losses before icache takes priority for one grant.
- MAX_OUTSTANDING, 8: maximum in-flight loads per requester; further requests from that requester are blocked.
- XLEN, `XLEN: address width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- icache2arb_command  in  2  BUS_NONE/BUS_LOAD from icache (BUS_STORE from icache is illegal and is ignored)
- icache2arb_addr  in  XLEN  icache request address, 8-byte aligned
- dcache2arb_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE from dcache
- dcache2arb_addr  in  XLEN  dcache request address
- dcache2arb_data  in  64  dcache store data
- arb2mem_command  out  2  command to memory
- arb2mem_addr  out  XLEN  address to memory
- arb2mem_data  out  64  store data to memory (dcache2arb_data when dcache is granted, else 0)
- mem2arb_response  in  4  memory acceptance tag; 0 = rejected
- mem2arb_data  in  64  returned load data
- mem2arb_tag  in  4  tag of returned data; 0 = no return
- arb2icache_response  out  4  mem2arb_response if icache is granted, else 0
- arb2icache_data  out  64  returned data for icache
- arb2icache_tag  out  4  returned tag for icache; 0 when not the owner
- arb2dcache_response  out  4  mem2arb_response if dcache is granted, else 0
- arb2dcache_data  out  64  returned data for dcache
- arb2dcache_tag  out  4  returned tag for dcache; 0 when not the owner
- arb_dcache_granted  out  1  combinational: dcache holds the bus this cycle
- arb_tag_error  out  1  sticky: unknown returning tag, or accepted tag already owned

Behaviour:
- State:
  - owner_valid[15:0] and owner_is_d[15:0]
  - i_outst and d_outst counters, width $clog2(MAX_OUTSTANDING+1)
  - starve_cnt, width $clog2(STARVE_LIMIT+1)
  - err flag
- Asynchronous reset clears all state to 0. While reset is high:
  - arb2mem_command=BUS_NONE, arb2mem_addr=0, arb2mem_data=0
  - all response/tag outputs are 0; arb_dcache_granted=0; arb_tag_error=0
- Eligibility:
  - i_req = icache2arb_command==BUS_LOAD && i_outst<MAX_OUTSTANDING.
  - d_req = dcache command!=BUS_NONE && (command==BUS_STORE || d_outst<MAX_OUTSTANDING).
- Grant (combinational, zero latency):
  - Both requesting and starve_cnt==STARVE_LIMIT → icache.
  - Otherwise both requesting → dcache.
  - Otherwise the single requester.
  - Otherwise none: command=BUS_NONE, addr=0, data=0.
- Granted requester's command/addr(/data) pass straight through to memory. The loser sees response 0 and must hold and retry.
- Acceptance = granted && mem2arb_response!=0.
- On an accepted BUS_LOAD, at the clock edge:
  - owner_valid[resp]<=1; owner_is_d[resp]<=granted==dcache.
  - Requester's outstanding counter increments.
  - If owner_valid[resp] was already 1 and is not cleared this same cycle, set err (the entry is still overwritten).
- Accepted BUS_STORE: no table entry, no counter change.
- Return (mem2arb_tag!=0, combinational):
  - If owner_valid[tag], the owner gets tag and mem2arb_data; the other side gets tag 0 and data 0.
  - At the edge: owner_valid[tag]<=0 and the owner's counter decrements.
  - If !owner_valid[tag], neither side receives it and err<=1.
- Same-tag return and acceptance in one cycle: clear first, then set. The new entry survives and no error is raised.
- Same-requester increment and decrement in one cycle: the counter holds.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when i_req is true and icache is not granted, or is granted but mem2arb_response==0.
  - Cleared when the icache load is accepted, or when i_req is false.
  - Priority therefore persists across memory rejections.
- Counters never wrap. A decrement at 0 is suppressed and sets err.

Test Plan:
- Dcache-only LOAD 0x100, response 3; later tag 3 with data 0xDEAD → arb2dcache_response=3, then arb2dcache_tag=3 with data 0xDEAD; arb2icache_tag=0; d_outst returns to 0.
- Icache and dcache both requesting LOAD every cycle, memory always accepting → dcache wins 4 cycles, icache wins on cycle 5 (STARVE_LIMIT=4), starve_cnt returns to 0, pattern repeats.
- Icache granted by starvation but mem2arb_response=0 for 2 cycles → icache keeps the grant each cycle until accepted; dcache response stays 0 throughout.
- Icache issues 8 accepted loads with no returns → 9th request is blocked, dcache is granted that cycle, and one tag return unblocks the icache the next cycle.
- Tag 5 returns for dcache in the same cycle a new icache load is accepted with tag 5 → dcache receives the data, the table shows tag 5 owned by icache, arb_tag_error stays 0.
- Return of tag 9 with no owner → no requester sees the tag, arb_tag_error=1 and stays 1. Reset asserted mid-stream → all outputs read 0 immediately, before the next clock edge.
